// File: rtl/card_dealer.sv
// Card producer for the bell game: paced flips onto two piles, frozen by the bell,
// cleared when scoring finishes. Card draws come from a free-running 16-bit Galois LFSR.
module card_dealer #(
    parameter int          DEAL_PERIOD = 50,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       bell,
    input  logic       round_done,
    output logic [1:0] c1,
    output logic [2:0] n1,
    output logic [1:0] c2,
    output logic [2:0] n2,
    output logic       card_valid,
    output logic       new_card,
    output logic [7:0] count,
    output logic       turn,
    output logic       dealing
);

    typedef enum logic [1:0] {IDLE, DEAL_WAIT, FROZEN, CLEAR} state_e;

    localparam logic [15:0] LAST_TICK = 16'(DEAL_PERIOD - 1);
    localparam logic [15:0] TAPS      = 16'hB400;

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  c1_q, c1_d, c2_q, c2_d;
    logic [2:0]  n1_q, n1_d, n2_q, n2_d;
    logic        card_valid_q, card_valid_d;
    logic        new_card_q, new_card_d;
    logic [7:0]  count_q, count_d;
    logic        turn_q, turn_d;
    logic        dealing_q, dealing_d;

    logic [1:0]  draw_c;
    logic [2:0]  draw_n;
    logic        flip;

    // Number is (lfsr[4:2] mod 5) + 1 so an empty pile (0) never collides with a card.
    always_comb begin
        draw_c = lfsr_q[1:0];
        case (lfsr_q[4:2])
            3'd0:    draw_n = 3'd1;
            3'd1:    draw_n = 3'd2;
            3'd2:    draw_n = 3'd3;
            3'd3:    draw_n = 3'd4;
            3'd4:    draw_n = 3'd5;
            3'd5:    draw_n = 3'd1;
            3'd6:    draw_n = 3'd2;
            default: draw_n = 3'd3;
        endcase
    end

    // Bell wins over a flip due on the same edge.
    assign flip = (state_q == DEAL_WAIT) && !bell && (timer_q == LAST_TICK);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            lfsr_q       <= SEED;
            c1_q         <= '0;
            n1_q         <= '0;
            c2_q         <= '0;
            n2_q         <= '0;
            card_valid_q <= 1'b0;
            new_card_q   <= 1'b0;
            count_q      <= '0;
            turn_q       <= 1'b0;
            dealing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            lfsr_q       <= lfsr_d;
            c1_q         <= c1_d;
            n1_q         <= n1_d;
            c2_q         <= c2_d;
            n2_q         <= n2_d;
            card_valid_q <= card_valid_d;
            new_card_q   <= new_card_d;
            count_q      <= count_d;
            turn_q       <= turn_d;
            dealing_q    <= dealing_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start)      state_d = DEAL_WAIT;
            DEAL_WAIT: if (bell)       state_d = FROZEN;
            FROZEN:    if (round_done) state_d = CLEAR;
            CLEAR:                     state_d = DEAL_WAIT;
            default:                   state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_d       = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 16'h0000);
        timer_d      = timer_q;
        c1_d         = c1_q;
        n1_d         = n1_q;
        c2_d         = c2_q;
        n2_d         = n2_q;
        card_valid_d = card_valid_q;
        new_card_d   = 1'b0;
        count_d      = count_q;
        turn_d       = turn_q;
        dealing_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (start) timer_d = '0;
            end
            DEAL_WAIT: begin
                if (flip) begin
                    if (!turn_q) begin
                        c1_d = draw_c;
                        n1_d = draw_n;
                    end else begin
                        c2_d         = draw_c;
                        n2_d         = draw_n;
                        card_valid_d = 1'b1;
                    end
                    turn_d     = ~turn_q;
                    count_d    = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    new_card_d = 1'b1;
                    timer_d    = '0;
                end else if (!bell) begin
                    timer_d = timer_q + 16'd1;
                end
            end
            FROZEN: begin
                if (round_done) begin
                    c1_d         = '0;
                    n1_d         = '0;
                    c2_d         = '0;
                    n2_d         = '0;
                    card_valid_d = 1'b0;
                    count_d      = '0;
                    turn_d       = 1'b0;
                end
            end
            CLEAR: begin
                timer_d = '0;
            end
            default: ;
        endcase
    end

    assign c1         = c1_q;
    assign n1         = n1_q;
    assign c2         = c2_q;
    assign n2         = n2_q;
    assign card_valid = card_valid_q;
    assign new_card   = new_card_q;
    assign count      = count_q;
    assign turn       = turn_q;
    assign dealing    = dealing_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: pacing, bell collision, clear, reset mid-game,
// count saturation and per-flip card values against a software LFSR.
module tb_card_dealer;

    localparam int          DP   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst, start, bell, round_done;
    logic [1:0] c1, c2;
    logic [2:0] n1, n2;
    logic       card_valid, new_card, turn, dealing;
    logic [7:0] count;

    card_dealer #(.DEAL_PERIOD(DP), .SEED(SEED)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bell(bell), .round_done(round_done),
        .c1(c1), .n1(n1), .c2(c2), .n2(n2), .card_valid(card_valid),
        .new_card(new_card), .count(count), .turn(turn), .dealing(dealing)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [15:0] m_lfsr, pre;
    int e_c1, e_n1, e_c2, e_n2, e_cnt, e_turn, e_cv;
    int num_tab [8] = '{1, 2, 3, 4, 5, 1, 2, 3};

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // One clock edge; the reference LFSR follows the DUT's register, pre keeps the value drawn from.
    task automatic tick();
        pre = m_lfsr;
        @(posedge clk);
        m_lfsr = rst ? SEED : lfsr_step(pre);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clear_model();
        e_c1 = 0; e_n1 = 0; e_c2 = 0; e_n2 = 0; e_cnt = 0; e_turn = 0; e_cv = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_c1"}, 32'(c1), e_c1);
        chk({tag, "_n1"}, 32'(n1), e_n1);
        chk({tag, "_c2"}, 32'(c2), e_c2);
        chk({tag, "_n2"}, 32'(n2), e_n2);
        chk({tag, "_count"}, 32'(count), e_cnt);
        chk({tag, "_turn"}, 32'(turn), e_turn);
        chk({tag, "_valid"}, 32'(card_valid), e_cv);
    endtask

    task automatic model_flip();
        int c, n;
        c = int'(pre[1:0]);
        n = num_tab[pre[4:2]];
        if (e_turn == 0) begin
            e_c1 = c; e_n1 = n;
        end else begin
            e_c2 = c; e_n2 = n; e_cv = 1;
        end
        e_turn = 1 - e_turn;
        if (e_cnt < 255) e_cnt++;
    endtask

    // Waits (bounded) for the next new_card pulse and checks its spacing and the table state.
    task automatic wait_flip(input int gap, input string tag);
        int k;
        bit seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < gap + 3) begin
            tick();
            k++;
            if (new_card === 1'b1) seen = 1'b1;
        end
        chk({tag, "_gap"}, 32'(k), gap);
        if (seen) begin
            model_flip();
            check_all(tag);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bell = 1'b0; round_done = 1'b0;
        clear_model();
        tick();
        tick();
        rst = 1'b0;
        check_all("reset");
        chk("reset_dealing", 32'(dealing), 0);
        chk("reset_new_card", 32'(new_card), 0);

        // Pacing: start at edge 0, flips at edges 4, 8, 12.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_dealing", 32'(dealing), 1);
        chk("start_count", 32'(count), 0);
        wait_flip(DP, "pace1");
        chk("pace1_n2_empty", 32'(n2), 0);
        tick();
        chk("pace_pulse_one_cycle", 32'(new_card), 0);
        wait_flip(DP - 1, "pace2");
        chk("pace2_valid", 32'(card_valid), 1);
        wait_flip(DP, "pace3");

        // Bell on the edge where the fourth flip is due.
        repeat (DP - 1) tick();
        bell = 1'b1;
        tick();
        bell = 1'b0;
        chk("bell_new_card", 32'(new_card), 0);
        chk("bell_dealing", 32'(dealing), 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("frozen_new_card", 32'(new_card), 0);
            check_all("frozen");
        end

        // Clear; bell during the CLEAR cycle must be ignored.
        round_done = 1'b1;
        tick();
        round_done = 1'b0;
        clear_model();
        check_all("clear");
        chk("clear_dealing", 32'(dealing), 1);
        bell = 1'b1;
        tick();
        bell = 1'b0;
        wait_flip(DP, "after_clear");
        chk("after_clear_pile1", 32'(turn), 1);

        // Reset while FROZEN.
        bell = 1'b1;
        tick();
        bell = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        check_all("rst_frozen");
        chk("rst_frozen_dealing", 32'(dealing), 0);
        chk("rst_frozen_new_card", 32'(new_card), 0);
        bell = 1'b1; round_done = 1'b1;
        repeat (10) tick();
        bell = 1'b0; round_done = 1'b0;
        chk("idle_ignore_count", 32'(count), 0);
        chk("idle_ignore_dealing", 32'(dealing), 0);

        // Reset while in DEAL_WAIT.
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_flip(DP, "rs2");
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        check_all("rst_wait");
        chk("rst_wait_dealing", 32'(dealing), 0);
        repeat (2 * DP) tick();
        chk("rst_wait_idle_count", 32'(count), 0);
        chk("rst_wait_idle_dealing", 32'(dealing), 0);

        // 1000 flips: exact card values per flip, count saturates at 255.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 1000; i++) wait_flip(DP, "run");
        chk("sat_count", 32'(count), 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
